// File: rtl/bell_measure_unit.sv
// Bell-basis measurement unit: CNOT (control = qubit1), H on qubit1, squaring
// into probabilities, then sampling the outcome against a free-running LFSR.
// A single shared signed multiplier is time-multiplexed over ROT and SQR.
module bell_measure_unit #(
  parameter logic [15:0]        SEED      = 16'hACE1,
  parameter logic signed [31:0] INV_SQRT2 = 32'sh0000B505
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] state_00_in,
  input  logic [31:0] state_01_in,
  input  logic [31:0] state_10_in,
  input  logic [31:0] state_11_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  outcome,
  output logic [31:0] prob_00,
  output logic [31:0] prob_01,
  output logic [31:0] prob_10,
  output logic [31:0] prob_11,
  output logic [15:0] rand_out,
  output logic        err_zero
);

  typedef enum logic [2:0] {IDLE, ROT, SQR, SAMPLE, DONE} state_t;

  localparam logic signed [65:0] S32_MAX = 66'sd2147483647;
  localparam logic signed [65:0] S32_MIN = ~S32_MAX;
  localparam logic signed [65:0] ONE_Q   = 66'sd65536;

  state_t             state_q;
  logic [1:0]         step_q;
  logic signed [31:0] a_q [4];    // CNOT-applied amplitudes, index {q1,q0}
  logic signed [31:0] h_q [4];    // rotated amplitudes, index {q1,q0}
  logic [31:0]        p_q [4];    // working probabilities
  logic [31:0]        prob_q [4];
  logic [1:0]         outcome_q;
  logic [15:0]        rand_q;
  logic               err_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [15:0]        lfsr_q, lfsr_d;

  logic signed [32:0] op_a, op_b;
  logic signed [65:0] prod, prod_sh;
  logic signed [31:0] rot_res;
  logic [31:0]        sqr_res;
  logic [1:0]         h_idx;
  logic [17:0]        r_ext, c0, c1, c2, c3;
  logic [1:0]         outcome_d;
  logic               err_d;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign outcome   = outcome_q;
  assign prob_00   = prob_q[0];
  assign prob_01   = prob_q[1];
  assign prob_10   = prob_q[2];
  assign prob_11   = prob_q[3];
  assign rand_out  = rand_q;
  assign err_zero  = err_q;

  // ROT order h00,h10,h01,h11 maps step {b1,b0} to h index {b0,b1}
  assign h_idx = {step_q[0], step_q[1]};

  // Galois LFSR next value, mask 0xB400
  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_d = (lfsr_q >> 1) ^ 16'hB400;
  end

  // Shared multiplier: operand select, floor shift by 16, then saturation
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (state_q == ROT) begin
      if (step_q[0]) op_a = 33'(a_q[{1'b0, step_q[1]}]) - 33'(a_q[{1'b1, step_q[1]}]);
      else           op_a = 33'(a_q[{1'b0, step_q[1]}]) + 33'(a_q[{1'b1, step_q[1]}]);
      op_b = 33'(INV_SQRT2);
    end else begin
      op_a = 33'(h_q[step_q]);
      op_b = 33'(h_q[step_q]);
    end
    prod    = 66'(op_a) * 66'(op_b);
    prod_sh = prod >>> 16;
    if (prod_sh > S32_MAX)      rot_res = 32'sh7FFFFFFF;
    else if (prod_sh < S32_MIN) rot_res = 32'sh80000000;
    else                        rot_res = prod_sh[31:0];
    if (prod_sh > ONE_Q) sqr_res = 32'h00010000;
    else                 sqr_res = prod_sh[31:0];
  end

  // Cumulative-probability sampling against the current LFSR value
  always_comb begin
    r_ext = {2'b00, lfsr_q};
    c0 = {1'b0, p_q[0][16:0]};
    c1 = c0 + {1'b0, p_q[1][16:0]};
    c2 = c1 + {1'b0, p_q[2][16:0]};
    c3 = c2 + {1'b0, p_q[3][16:0]};
    err_d = (p_q[0] == '0) && (p_q[1] == '0) && (p_q[2] == '0) && (p_q[3] == '0);
    if (r_ext < c0)         outcome_d = 2'd0;
    else if (r_ext < c1)    outcome_d = 2'd1;
    else if (r_ext < c2)    outcome_d = 2'd2;
    else if (r_ext < c3)    outcome_d = 2'd3;
    else if (p_q[3] != '0)  outcome_d = 2'd3;
    else if (p_q[2] != '0)  outcome_d = 2'd2;
    else if (p_q[1] != '0)  outcome_d = 2'd1;
    else                    outcome_d = 2'd0;
  end

  // LFSR runs every clock, independent of the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  // Measurement FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      outcome_q   <= '0;
      rand_q      <= '0;
      err_q       <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        a_q[i]    <= '0;
        h_q[i]    <= '0;
        p_q[i]    <= '0;
        prob_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            a_q[0]     <= state_00_in;
            a_q[1]     <= state_01_in;
            a_q[2]     <= state_11_in;
            a_q[3]     <= state_10_in;
            in_ready_q <= 1'b0;
            step_q     <= '0;
            state_q    <= ROT;
          end
        end
        ROT: begin
          h_q[h_idx] <= rot_res;
          step_q     <= step_q + 2'd1;
          if (step_q == 2'd3) state_q <= SQR;
        end
        SQR: begin
          p_q[step_q] <= sqr_res;
          step_q      <= step_q + 2'd1;
          if (step_q == 2'd3) state_q <= SAMPLE;
        end
        SAMPLE: begin
          for (int unsigned i = 0; i < 4; i++) prob_q[i] <= p_q[i];
          outcome_q <= outcome_d;
          rand_q    <= lfsr_q;
          err_q     <= err_d;
          state_q   <= DONE;
        end
        DONE: begin
          // results settle one edge before out_valid rises
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bell_measure_unit.sv
// Directed bench for bell_measure_unit: Bell states, superposition sampling,
// all-zero input, backpressure and asynchronous reset mid-measurement.
module tb_bell_measure_unit;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [31:0] P    = 32'h0000B505;
  localparam logic [31:0] N    = 32'hFFFF4AFB;
  localparam logic [31:0] ONE  = 32'h00010000;
  localparam logic [31:0] HALF = 32'h00008000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] state_00_in = '0, state_01_in = '0, state_10_in = '0, state_11_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  outcome;
  logic [31:0] prob_00, prob_01, prob_10, prob_11;
  logic [15:0] rand_out;
  logic        err_zero;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [15:0] m_lfsr;
  logic [15:0] exp_rand;
  int unsigned cnt00;

  bell_measure_unit #(.SEED(SEED), .INV_SQRT2(32'sh0000B505)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .state_00_in(state_00_in), .state_01_in(state_01_in),
    .state_10_in(state_10_in), .state_11_in(state_11_in),
    .out_valid(out_valid), .out_ready(out_ready), .outcome(outcome),
    .prob_00(prob_00), .prob_01(prob_01), .prob_10(prob_10), .prob_11(prob_11),
    .rand_out(rand_out), .err_zero(err_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // reference LFSR, tracks the DUT generator cycle for cycle
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic measure(input string tag, input logic [31:0] s0, s1, s2, s3);
    int unsigned n;
    n = 0;
    while (!in_ready && n < 30) begin @(posedge clk); #1; n++; end
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    state_00_in = s0; state_01_in = s1; state_10_in = s2; state_11_in = s3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_rand = m_lfsr;
    repeat (8) exp_rand = lfsr_step(exp_rand);
    n = 0;
    while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
    check({tag, "_lat"}, n, 32'd10);
    check({tag, "_rand"}, 32'(rand_out), 32'(exp_rand));
  endtask

  task automatic check_res(input string tag, input logic [31:0] e0, e1, e2, e3,
                           input logic [1:0] eoc, input logic eerr);
    check({tag, "_p00"}, prob_00, e0);
    check({tag, "_p01"}, prob_01, e1);
    check({tag, "_p10"}, prob_10, e2);
    check({tag, "_p11"}, prob_11, e3);
    check({tag, "_oc"},  32'(outcome), 32'(eoc));
    check({tag, "_err"}, 32'(err_zero), 32'(eerr));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ovdrop"}, 32'(out_valid), 32'd0);
    check({tag, "_irdy"},   32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    #12;
    check("rst_ov",  32'(out_valid), 32'd0);
    check("rst_ir",  32'(in_ready),  32'd0);
    check_res("rst", '0, '0, '0, '0, 2'd0, 1'b0);
    check("rst_rand", 32'(rand_out), 32'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;
    check("rel_ir", 32'(in_ready), 32'd1);

    measure("phip", P, '0, '0, P);  check_res("phip", ONE, '0, '0, '0, 2'd0, 1'b0); consume("phip");
    measure("phim", P, '0, '0, N);  check_res("phim", '0, '0, ONE, '0, 2'd2, 1'b0); consume("phim");
    measure("psip", '0, P, P, '0);  check_res("psip", '0, ONE, '0, '0, 2'd1, 1'b0); consume("psip");
    measure("psim", '0, P, N, '0);  check_res("psim", '0, '0, '0, ONE, 2'd3, 1'b0); consume("psim");
    measure("zero", '0, '0, '0, '0); check_res("zero", '0, '0, '0, '0, 2'd0, 1'b1); consume("zero");

    // equal superposition of |00> and |10> after rotation
    cnt00 = 0;
    for (int i = 0; i < 1000; i++) begin
      measure("sup", ONE, '0, '0, '0);
      check("sup_oc", 32'(outcome), (exp_rand < 16'h8000) ? 32'd0 : 32'd2);
      check("sup_p00", prob_00, HALF);
      check("sup_p10", prob_10, HALF);
      if (outcome == 2'd0) cnt00++;
      consume("sup");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    check("sup_frac", 32'(cnt00 >= 450 && cnt00 <= 550), 32'd1);

    // backpressure: result held, stray in_valid pulses ignored
    measure("bp", P, '0, '0, P);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      state_00_in = '0; state_01_in = P; state_10_in = N; state_11_in = '0;
      @(posedge clk); #1;
      check("bp_ov",   32'(out_valid), 32'd1);
      check("bp_ir",   32'(in_ready),  32'd0);
      check("bp_oc",   32'(outcome),   32'd0);
      check("bp_p00",  prob_00, ONE);
      check("bp_rand", 32'(rand_out), 32'(exp_rand));
    end
    in_valid = 1'b0;
    consume("bp");
    measure("post_bp", '0, P, P, '0); check_res("post_bp", '0, ONE, '0, '0, 2'd1, 1'b0);
    consume("post_bp");

    // asynchronous reset while squaring
    state_00_in = P; state_01_in = '0; state_10_in = '0; state_11_in = N;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_ov", 32'(out_valid), 32'd0);
    check("arst_ir", 32'(in_ready),  32'd0);
    check_res("arst", '0, '0, '0, '0, 2'd0, 1'b0);
    check("arst_rand", 32'(rand_out), 32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check("arel_ir", 32'(in_ready), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    check("arel_noout", 32'(out_valid), 32'd0);
    measure("fresh", P, '0, '0, P); check_res("fresh", ONE, '0, '0, '0, 2'd0, 1'b0);
    consume("fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
